// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory opcodes, data-memory FSM states and the
// load-lane extension helper used by the MEM-stage responder.
package mips_pkg;

    // Load/store opcodes handled by the data-memory responder
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

    function automatic logic op_is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic op_supported(input logic [5:0] op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    // Byte accesses are always aligned; halfwords need bit 0 clear, words bits 1:0 clear
    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] lo);
        logic ok;
        ok = 1'b1;
        case (op)
            OP_LH, OP_LHU, OP_SH: ok = ~lo[0];
            OP_LW, OP_SW:         ok = (lo == 2'b00);
            default:              ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Select the addressed lane of a little-endian word and sign/zero extend it
    function automatic logic [31:0] extend_lane(input logic [5:0]  op,
                                                input logic [31:0] word,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0, h};
            OP_LW:   r = word;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, DEPTH_WORDS x 32, byte write enables,
// one-cycle registered read. Contents are never cleared.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           CLK,
    input  logic                           en,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane writes; a read (no lanes enabled) refreshes rdata, otherwise rdata holds
    always_ff @(posedge CLK) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// MEM-stage data-memory responder. Captures one load/store, stalls the pipeline
// for LATENCY+1 cycles, then pulses MEM_Valid with the extended load result.
module dmem_resp
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               MEM_Req,
    input  logic [5:0]         MEM_Opcode,
    input  logic [31:0]        MEM_Addr,
    input  logic [31:0]        MEM_WData,
    output logic               MEM_Stall,
    output logic               MEM_Valid,
    output logic               MEM_Err,
    output logic signed [31:0] MEM_RD_DATA
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    dmem_state_t   state;
    logic [CW-1:0] cnt;

    // Captured request; only the bits that select a word and lane are kept
    logic [5:0]    req_op;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;

    // Describes how to present the RAM read word during and after DONE
    logic          rd_zero;
    logic [5:0]    rd_op;
    logic [1:0]    rd_lane;

    logic          acc_ok;
    logic          fire;
    logic          ram_en;
    logic [3:0]    lane_be;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    // Upper address bits do not take part in decoding; accesses wrap
    logic          unused_addr;
    assign unused_addr = ^MEM_Addr[31:AW+2];

    // Access decode: legality, byte enables and lane-replicated store data
    always_comb begin
        acc_ok    = op_supported(req_op) && is_aligned(req_op, req_addr[1:0]);
        // Final BUSY cycle; a reset in this cycle abandons the access
        fire      = (state == BUSY) && (cnt == '0) && !RESET;
        ram_en    = fire && acc_ok;
        lane_be   = 4'b0000;
        ram_wdata = req_wdata;
        case (req_op)
            OP_SB: begin
                lane_be   = 4'b0001 << req_addr[1:0];
                ram_wdata = {4{req_wdata[7:0]}};
            end
            OP_SH: begin
                lane_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{req_wdata[15:0]}};
            end
            OP_SW: begin
                lane_be   = 4'b1111;
            end
            default: begin
                lane_be   = 4'b0000;
            end
        endcase
        ram_we = ram_en ? lane_be : 4'b0000;
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .CLK   (CLK),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (req_addr[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Stall is combinational so the pipeline freezes in the cycle the request appears
    always_comb begin
        MEM_Stall = ((state == IDLE) && MEM_Req) || (state == BUSY);
    end

    // Result view: RAM rdata and rd_* only change on entry to DONE, so this holds between DONEs
    always_comb begin
        MEM_RD_DATA = rd_zero ? 32'sh0 : $signed(extend_lane(rd_op, ram_rdata, rd_lane));
    end

    // Request FSM with latency counter and registered completion outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            req_op    <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            MEM_Valid <= 1'b0;
            MEM_Err   <= 1'b0;
            rd_zero   <= 1'b1;
            rd_op     <= '0;
            rd_lane   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    MEM_Valid <= 1'b0;
                    MEM_Err   <= 1'b0;
                    if (MEM_Req) begin
                        req_op    <= MEM_Opcode;
                        req_addr  <= MEM_Addr[AW+1:0];
                        req_wdata <= MEM_WData;
                        cnt       <= CNT_INIT;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state     <= DONE;
                        MEM_Valid <= 1'b1;
                        MEM_Err   <= ~acc_ok;
                        // Stores and rejected accesses report zero data
                        rd_zero   <= ~(acc_ok && op_is_load(req_op));
                        rd_op     <= req_op;
                        rd_lane   <= req_addr[1:0];
                    end
                end
                DONE: begin
                    // The same instruction is still presented here, so MEM_Req is ignored
                    MEM_Valid <= 1'b0;
                    MEM_Err   <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Randomised self-checking bench for dmem_resp against a byte-array memory model.
module tb_dmem_resp;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam int unsigned BYTES = DEPTH * 4;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               MEM_Req;
    logic [5:0]         MEM_Opcode;
    logic [31:0]        MEM_Addr;
    logic [31:0]        MEM_WData;
    logic               MEM_Stall;
    logic               MEM_Valid;
    logic               MEM_Err;
    logic signed [31:0] MEM_RD_DATA;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mem_b [BYTES];

    dmem_resp #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .MEM_Req     (MEM_Req),
        .MEM_Opcode  (MEM_Opcode),
        .MEM_Addr    (MEM_Addr),
        .MEM_WData   (MEM_WData),
        .MEM_Stall   (MEM_Stall),
        .MEM_Valid   (MEM_Valid),
        .MEM_Err     (MEM_Err),
        .MEM_RD_DATA (MEM_RD_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Architectural view: access size from opcode, alignment by modulo, value by arithmetic
    function automatic void model(input logic [5:0] op, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic err);
        int     size;
        bit     sgn;
        bit     st;
        int     a;
        longint v;
        size = 0; sgn = 0; st = 0;
        case (op)
            LB:      begin size = 1; sgn = 1; end
            LH:      begin size = 2; sgn = 1; end
            LW:      size = 4;
            LBU:     size = 1;
            LHU:     size = 2;
            SB:      begin size = 1; st = 1; end
            SH:      begin size = 2; st = 1; end
            SW:      begin size = 4; st = 1; end
            default: size = 0;
        endcase
        rd  = 32'h0;
        err = 1'b0;
        a   = int'(addr % BYTES);
        if (size == 0 || (a % size) != 0) begin
            err = 1'b1;
            return;
        end
        if (st) begin
            for (int i = 0; i < size; i++) mem_b[a + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = size - 1; i >= 0; i--) v = v * 256 + longint'(mem_b[a + i]);
            if (sgn && v >= (longint'(1) << (8*size - 1))) v = v - (longint'(1) << (8*size));
            rd = v[31:0];
        end
    endfunction

    // Present one request, wait out the stall, then check the DONE cycle
    task automatic run(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input string tag);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        model(op, addr, wd, exp_rd, exp_err);
        @(negedge CLK);
        MEM_Req = 1'b1; MEM_Opcode = op; MEM_Addr = addr; MEM_WData = wd;
        #1;
        n = 0;
        while (MEM_Stall && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        MEM_Req = 1'b0;
        check({tag, " stall cycles"}, 32'(n), 32'(LAT + 1));
        check({tag, " valid"}, {31'h0, MEM_Valid}, 32'h1);
        check({tag, " err"}, {31'h0, MEM_Err}, {31'h0, exp_err});
        check({tag, " rd_data"}, MEM_RD_DATA, exp_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0]  ops [10];
        logic [31:0] e_rd;
        logic        e_err;
        int          pulses;
        int          first;
        int          second;

        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h22, 6'h00};
        RESET = 1'b1; MEM_Req = 1'b0; MEM_Opcode = '0; MEM_Addr = '0; MEM_WData = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        check("reset stall", {31'h0, MEM_Stall}, 32'h0);
        check("reset valid", {31'h0, MEM_Valid}, 32'h0);
        check("reset err", {31'h0, MEM_Err}, 32'h0);
        check("reset rd_data", MEM_RD_DATA, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("post-reset stall", {31'h0, MEM_Stall}, 32'h0);

        // Word round trip and extension
        run(SW, 32'h40, 32'h1234_5678, "sw 0x40");
        run(LW, 32'h40, 32'h0, "lw 0x40");
        check("lw 0x40 literal", MEM_RD_DATA, 32'h1234_5678);
        run(LH, 32'h42, 32'h0, "lh 0x42");
        check("lh 0x42 literal", MEM_RD_DATA, 32'h0000_1234);
        run(SB, 32'h43, 32'h0000_0080, "sb 0x43");
        run(LB, 32'h43, 32'h0, "lb 0x43");
        check("lb 0x43 literal", MEM_RD_DATA, 32'hFFFF_FF80);
        run(LBU, 32'h43, 32'h0, "lbu 0x43");
        check("lbu 0x43 literal", MEM_RD_DATA, 32'h0000_0080);

        // Misaligned access leaves memory untouched
        run(LW, 32'h41, 32'h0, "lw misaligned");
        run(SH, 32'h41, 32'hFFFF_FFFF, "sh misaligned");
        run(LW, 32'h40, 32'h0, "lw 0x40 after err");

        // Wrap-around
        run(SW, 32'h1000, 32'hCAFE_F00D, "sw 0x1000");
        run(LW, 32'h0, 32'h0, "lw 0x0 wrap");
        check("wrap literal", MEM_RD_DATA, 32'hCAFE_F00D);

        // Reset in the first BUSY cycle abandons the pending store
        run(SW, 32'h80, 32'h1111_1111, "sw 0x80 init");
        @(negedge CLK);
        MEM_Req = 1'b1; MEM_Opcode = SW; MEM_Addr = 32'h80; MEM_WData = 32'hDEAD_BEEF;
        #1;
        check("rst-busy stall first cycle", {31'h0, MEM_Stall}, 32'h1);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; MEM_Req = 1'b0;
        #1;
        check("rst-busy stall dropped", {31'h0, MEM_Stall}, 32'h0);
        check("rst-busy valid", {31'h0, MEM_Valid}, 32'h0);
        check("rst-busy rd_data", MEM_RD_DATA, 32'h0);
        repeat (3) @(negedge CLK);
        #1;
        check("rst-busy no late valid", {31'h0, MEM_Valid}, 32'h0);
        run(LW, 32'h80, 32'h0, "lw 0x80 after rst");

        // Back-to-back: request held across two instructions
        model(SW, 32'h208, 32'h55AA_33CC, e_rd, e_err);
        @(negedge CLK);
        MEM_Req = 1'b1; MEM_Opcode = SW; MEM_Addr = 32'h208; MEM_WData = 32'h55AA_33CC;
        #1;
        pulses = 0; first = -1; second = -1;
        for (int c = 0; c < 14; c++) begin
            if (MEM_Valid) begin
                pulses++;
                if (pulses == 1) begin
                    first = c;
                    check("b2b done stall", {31'h0, MEM_Stall}, 32'h0);
                    check("b2b sw rd_data", MEM_RD_DATA, 32'h0);
                    model(LW, 32'h208, 32'h0, e_rd, e_err);
                    @(posedge CLK);
                    #1;
                    MEM_Opcode = LW; MEM_WData = 32'h0;
                end else if (pulses == 2) begin
                    second = c;
                    check("b2b lw rd_data", MEM_RD_DATA, e_rd);
                    @(posedge CLK);
                    #1;
                    MEM_Req = 1'b0;
                end
            end
            @(negedge CLK);
            #1;
        end
        MEM_Req = 1'b0;
        check("b2b pulses", 32'(pulses), 32'd2);
        check("b2b first done", 32'(first), 32'(LAT + 1));
        check("b2b spacing", 32'(second - first), 32'(LAT + 2));

        // Randomised traffic in a pre-initialised window, with random high address bits
        for (int w = 0; w < 8; w++) run(SW, 32'h200 + 32'(4*w), $urandom, "init window");
        for (int k = 0; k < 40; k++) begin
            run(ops[$urandom_range(0, 9)],
                ($urandom & 32'hFFFF_F000) | (32'h200 + 32'($urandom_range(0, 31))),
                $urandom, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the MEM stage of the five-stage MIPS pipeline. It accepts one load/store request at a time from the MEM stage and performs the access after a fixed, parameterised latency. While the access is in flight it stalls the pipeline. Loads return sign- or zero-extended data on `MEM_RD_DATA`, which feeds the MEM/WB pipeline register.

## Interface
- `DEPTH_WORDS`, default 1024: memory depth in 32-bit words; power of two.
- `LATENCY`, default 2: number of BUSY cycles per access; must be ≥1.
- `CLK`  in  1: sole clock, rising edge.
- `RESET`  in  1: synchronous, active-high reset, sampled on the rising edge of `CLK`.
- `MEM_Req`  in  1: a load or store is present in the MEM stage.
- `MEM_Opcode`  in  6: MIPS opcode; lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B.
- `MEM_Addr`  in  32: byte address, taken from the MEM-stage ALU result.
- `MEM_WData`  in  32: store data from rt, right-aligned.
- `MEM_Stall`  out  1: freeze the PC and all pipeline registers up to and including EX/MEM.
- `MEM_Valid`  out  1: one-cycle pulse when an access completes.
- `MEM_Err`  out  1: qualifies `MEM_Valid`; set for a misaligned access or an unsupported opcode.
- `MEM_RD_DATA`  out  32 (signed): extended load result.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset enters IDLE.
- IDLE:
  - If `MEM_Req`=1, capture opcode, address and write data, load counter with LATENCY-1, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If counter ≠0, decrement it.
  - If counter =0, perform the access on the clock edge and go to DONE.
- DONE:
  - Assert `MEM_Valid`, then go to IDLE.
  - `MEM_Req` is ignored in DONE, because the same instruction is still presented during this cycle.
- `MEM_Stall` = (IDLE & `MEM_Req`) | BUSY. It is combinational so the pipeline freezes in the same cycle the request first appears.
- The MEM stage holds all request inputs stable while `MEM_Stall`=1. The captured copy is authoritative.
- Word index = `MEM_Addr`[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so accesses wrap modulo the memory size.
- Alignment rules: halfword accesses need Addr[0]=0; word accesses need Addr[1:0]=0.
  - A violation or an unsupported opcode performs no memory access.
  - The DONE cycle then gives `MEM_Err`=1 and `MEM_RD_DATA`=0.
- Stores:
  - sb writes `MEM_WData`[7:0] to byte lane Addr[1:0].
  - sh writes `MEM_WData`[15:0] to lanes {Addr[1],0}.
  - Lane 0 is bits [7:0] (little-endian).
  - `MEM_RD_DATA` is 0 in the DONE cycle of a store.
- Loads: the selected lane is sign-extended (lb, lh) or zero-extended (lbu, lhu).
- `MEM_RD_DATA` is registered. It updates on entry to DONE and holds until the next DONE.
- Memory contents are not affected by `RESET`.

## Timing
- Reset values: state IDLE; `MEM_Valid` 0; `MEM_Err` 0; `MEM_RD_DATA` 0; counter 0.
- `MEM_Stall` is 0 during reset and in the cycle after it, unless `MEM_Req`=1 in that cycle.
- Request first seen in cycle t: `MEM_Stall`=1 for cycles t..t+LATENCY, and DONE occurs in cycle t+LATENCY+1.
- Stall cost per access is LATENCY+1 cycles. With the default LATENCY of 2, the pipeline stalls for 3 cycles.
- Back-to-back requests: the next request is seen in the cycle after DONE. There is no overlap between accesses.
- `RESET` during BUSY abandons the access and does not write a pending store. The next cycle is IDLE with all outputs at their reset values.
- `RESET` and `MEM_Req` in the same cycle: reset wins and the request is not captured.
- LATENCY=1: BUSY lasts exactly one cycle.

## Structure
- The shared package `mips_pkg` holds:
  - the opcode constants listed above;
  - the state enum `dmem_state_t` {IDLE, BUSY, DONE};
  - the lane-extension function.
- Sub-module `dmem_ram`: a single-port synchronous RAM of DEPTH_WORDS×32 with a 4-bit byte-write-enable and one-cycle read. `dmem_resp` issues its read or write on the final BUSY cycle.
- The FSM, counter, alignment check and extension logic live in `dmem_resp`.

## Test plan
- Word round trip: sw 0x12345678 at address 0x40, then lw 0x40. Each access stalls for 3 cycles; the lw DONE cycle gives `MEM_RD_DATA`=0x12345678 with `MEM_Valid`=1 and `MEM_Err`=0.
- Byte and halfword extension:
  - sb 0x80 at 0x43, then lb 0x43 returns 0xFFFFFF80 and lbu 0x43 returns 0x00000080.
  - After the earlier word store, lh 0x42 returns 0x00001234.
- Misaligned access: lw at 0x41 gives DONE with `MEM_Err`=1 and data 0. A following lw 0x40 shows memory unchanged.
- Wrap-around: with DEPTH_WORDS=1024, sw 0xCAFEF00D at 0x1000, then lw 0x0 returns 0xCAFEF00D.
- Reset mid-operation: assert `RESET` in the first BUSY cycle of sw 0xDEADBEEF at 0x80. `MEM_Stall` drops the next cycle, and a later lw 0x80 returns the old contents.
- Back-to-back: hold `MEM_Req`=1 across two consecutive instructions. Exactly two `MEM_Valid` pulses occur, 4 cycles apart, and DONE never re-captures a request.
